mux_scan_sequencer: RTL



---
 rtl/mux_scan_pkg.sv | 34 +++
 rtl/mux_scan_sequencer_settle_counter.sv | 39 +++
 rtl/mux_scan_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// ---------------------------------------------------------------------------
// mux_scan_pkg
// Shared definitions for the mux scan sequencer: channel count, select width,
// the scan FSM state type and a small channel-search helper.
// Ports: none (package).
// ---------------------------------------------------------------------------
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Lowest enabled channel whose index is >= from.
    // Returns {found, index}; found=0 when no such channel exists.
    function automatic logic [SEL_W:0] find_chan(input logic [NUM_CH-1:0] mask,
                                                 input logic [SEL_W:0]    from);
        logic [SEL_W:0] hit;
        hit = '0;
        // Walk downwards so the lowest qualifying index is the last one written.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                hit = {1'b1, SEL_W'(i)};
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/mux_scan_sequencer_settle_counter.sv
// ---------------------------------------------------------------------------
// settle_counter
// Counts the cycles a select value has been held. While enable is high the
// count advances once per cycle; done is high during the SETTLE_CYC-th enabled
// cycle. clear has priority and returns the count to zero.
// Ports:
//   clk    in  1  clock, rising edge
//   rst_n  in  1  asynchronous active-low reset
//   clear  in  1  synchronous clear
//   enable in  1  count this cycle
//   done   out 1  current cycle is the last settle cycle
// ---------------------------------------------------------------------------
module settle_counter #(
    parameter int SETTLE_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int CNT_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign done = enable && (count == CNT_W'(SETTLE_CYC - 1));

endmodule

// File: rtl/mux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// mux_scan_sequencer
// Steps the select of a 4:1 bit mux through its channels, holds each select
// for SETTLE_CYC cycles, samples the mux output for one cycle and delivers the
// assembled 4-bit word over a valid/ready handshake.
//
// Handshake: data_valid rises when a word is ready and stays high, with
// data_out stable, until a cycle in which data_valid && data_ready are both
// high; the word is consumed at that clock edge.
//
// Optional build macro MUX_SCAN_CHAN_MASK_EN adds chan_mask: channels with a
// 0 mask bit are skipped entirely and read back as 0.
//
// Ports:
//   clk        in  1  clock, rising edge
//   rst_n      in  1  asynchronous active-low reset
//   start      in  1  begin a scan (honoured only in IDLE)
//   sel_out    out 2  mux select
//   mux_in     in  1  mux output
//   busy       out 1  high in every state except IDLE
//   data_out   out 4  assembled word, bit i sampled with sel_out = i
//   data_valid out 1  word available
//   data_ready in  1  consumer accepts the word
//   state      out 2  current FSM state (debug)
//   chan_mask  in  4  channel enable mask (MUX_SCAN_CHAN_MASK_EN only)
// ---------------------------------------------------------------------------
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [SEL_W-1:0]  sel_out,
    input  logic              mux_in,
    output logic              busy,
    output logic [NUM_CH-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output state_t            state
`ifdef MUX_SCAN_CHAN_MASK_EN
    ,
    input  logic [NUM_CH-1:0] chan_mask
`endif
);

    logic [NUM_CH-1:0] shadow;
    logic [NUM_CH-1:0] sample_word;
    logic [NUM_CH-1:0] mask_q;
    logic [NUM_CH-1:0] start_mask;
    logic [SEL_W:0]    first_hit;
    logic [SEL_W:0]    restart_hit;
    logic [SEL_W:0]    next_hit;
    logic              cnt_done;

`ifdef MUX_SCAN_CHAN_MASK_EN
    assign start_mask = chan_mask;
`else
    assign start_mask = '1;
    assign mask_q     = '1;
`endif

    // Channel to begin with on a fresh start, on a continuous restart, and
    // the channel following the one being sampled now.
    assign first_hit   = find_chan(start_mask, '0);
    assign restart_hit = find_chan(mask_q, '0);
    assign next_hit    = find_chan(mask_q, {1'b0, sel_out} + (SEL_W + 1)'(1));

    // Shadow with the bit being sampled this cycle already merged in, so the
    // final SAMPLE can publish the complete word in the same edge.
    always_comb begin
        sample_word          = shadow;
        sample_word[sel_out] = mux_in;
    end

    settle_counter #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != SETTLE),
        .enable (state == SETTLE),
        .done   (cnt_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel_out    <= '0;
            busy       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            shadow     <= '0;
`ifdef MUX_SCAN_CHAN_MASK_EN
            mask_q     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shadow <= '0;
                        busy   <= 1'b1;
`ifdef MUX_SCAN_CHAN_MASK_EN
                        mask_q <= start_mask;
`endif
                        if (first_hit[SEL_W]) begin
                            sel_out <= first_hit[SEL_W-1:0];
                            state   <= SETTLE;
                        end else begin
                            // Nothing enabled: publish an all-zero word at once.
                            data_out   <= '0;
                            data_valid <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt_done) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    shadow <= sample_word;
                    if (next_hit[SEL_W]) begin
                        sel_out <= next_hit[SEL_W-1:0];
                        state   <= SETTLE;
                    end else begin
                        data_out   <= sample_word & mask_q;
                        data_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (data_ready) begin
                        data_valid <= 1'b0;
                        if (CONTINUOUS) begin
                            shadow <= '0;
                            if (restart_hit[SEL_W]) begin
                                sel_out <= restart_hit[SEL_W-1:0];
                                state   <= SETTLE;
                            end else begin
                                // Empty mask keeps re-issuing the zero word.
                                data_out   <= '0;
                                data_valid <= 1'b1;
                            end
                        end else begin
                            sel_out <= '0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
